cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Merges the sram-like memory-side ports of the instruction cache and the data cache into one sram-like master port, which feeds the AXI bridge.
- Allows one outstanding transaction at a time.
- Data cache has priority; a starvation counter guarantees the instruction cache eventually gets a grant.
- Routes addr_ok/data_ok back only to the current owner.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants issued while inst_req is pending, after which inst is forced next. 0 means strict data priority (no forcing).
- CNT_W, 4: width of the starvation counter. Must satisfy STARVE_LIMIT < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_req  in  1  icache request, held until inst_addr_ok
- inst_wr  in  1  icache write flag
- inst_size  in  2  icache access size
- inst_addr  in  32  icache address
- inst_wdata  in  32  icache write data
- inst_rdata  out  32  read data to icache
- inst_addr_ok  out  1  address accepted, icache
- inst_data_ok  out  1  transaction done, icache
- data_req  in  1  dcache request, held until data_addr_ok
- data_wr  in  1  dcache write flag (WM = 1, RM = 0)
- data_size  in  2  dcache access size
- data_addr  in  32  dcache address
- data_wdata  in  32  dcache write data
- data_rdata  out  32  read data to dcache
- data_addr_ok  out  1  address accepted, dcache
- data_data_ok  out  1  transaction done, dcache
- mem_req  out  1  request to bridge
- mem_wr  out  1  write flag to bridge
- mem_size  out  2  size to bridge
- mem_addr  out  32  address to bridge
- mem_wdata  out  32  write data to bridge
- mem_rdata  in  32  read data from bridge
- mem_addr_ok  in  1  bridge accepted address
- mem_data_ok  in  1  bridge finished transaction

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state = IDLE, starve_cnt = 0.
- Outputs while in reset or IDLE: mem_req = 0, all addr_ok/data_ok = 0, mem_wr/size/addr/wdata driven from the data port.
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Grant decision in IDLE, registered (takes effect next cycle):
  - force = (STARVE_LIMIT != 0) & (starve_cnt >= STARVE_LIMIT) & inst_req.
  - force: go to I_ADDR, starve_cnt <= 0.
  - else if data_req: go to D_ADDR; starve_cnt <= starve_cnt + 1 if inst_req is high, else 0. Counter saturates at 2^CNT_W - 1.
  - else if inst_req: go to I_ADDR, starve_cnt <= 0.
  - else stay in IDLE.
- X_ADDR (X = I or D):
  - mem_req = X_req; mem_* fields muxed from port X.
  - X_addr_ok = mem_addr_ok & X_req.
  - mem_addr_ok & mem_data_ok in the same cycle: go to IDLE, and X_data_ok = 1 that cycle.
  - mem_addr_ok alone: go to X_DATA.
  - X_req dropped before any accept (protocol violation): go to IDLE, nothing issued.
- X_DATA:
  - mem_req = 0; mem_* fields remain muxed from X.
  - X_data_ok = mem_data_ok.
  - On mem_data_ok: go to IDLE.
- The non-owner port never sees addr_ok or data_ok.
- inst_rdata and data_rdata both equal mem_rdata (combinational broadcast); only data_ok qualifies it.
- Latency:
  - Request sampled in IDLE at cycle t: mem_req high at t+1; earliest X_addr_ok at t+1.
  - One IDLE bubble cycle follows every completion before the next grant.
- mem_data_ok arriving in IDLE (e.g. a stale response after reset mid-transaction) is dropped; no data_ok is generated.
- Reset mid-transaction: state returns to IDLE immediately; a pending master must re-request.
- inst_wr is passed through unchanged; no read-only check is applied.

Test Plan:
- Single dcache read:
  - Stimulus: data_req = 1, data_wr = 0, addr 0x0000_1004 at t0; bridge gives addr_ok at t2, data_ok with rdata 0xDEADBEEF at t4.
  - Required: mem_req high t1–t2; data_addr_ok only at t2; data_data_ok and data_rdata = 0xDEADBEEF at t4; inst_* handshakes stay 0.
- Simultaneous requests:
  - Stimulus: inst_req and data_req both rise at t0.
  - Required: first grant is D (mem_addr = data_addr); inst is granted in the cycle after D completes plus one IDLE cycle.
- Starvation, STARVE_LIMIT = 2:
  - Stimulus: inst_req held high while data_req re-asserts back-to-back.
  - Required: grant order D, D, I, D; starve_cnt = 0 after the I grant.
- Same-cycle accept and finish:
  - Stimulus: in D_ADDR, bridge asserts mem_addr_ok and mem_data_ok together.
  - Required: data_addr_ok and data_data_ok both pulse that cycle; state returns to IDLE next cycle; D_DATA is never entered.
- Dirty writeback then refill (WM then RM):
  - Stimulus: data_wr = 1, addr 0x0040_0010, wdata 0x12345678, followed by a data_wr = 0 read.
  - Required: mem_wr = 1 with mem_wdata = 0x12345678 on the first transaction; mem_wr = 0 on the second.
- Reset mid-transaction:
  - Stimulus: rst pulsed while in I_DATA; mem_data_ok arrives one cycle after reset releases.
  - Required: inst_data_ok stays 0; state is IDLE; starve_cnt = 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbiter merging the icache and dcache sram-like memory ports onto a single
// sram-like master port toward the AXI bridge. The data cache has priority.
// A starvation counter forces an instruction grant after STARVE_LIMIT data
// grants have been issued while an instruction request was waiting.
// Only one transaction is in flight at a time. Handshakes are returned only
// to the port that currently owns the bus.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
    localparam logic             LIMIT_EN  = (STARVE_LIMIT != 0);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_s;
    logic             force_inst_s;
    logic             sel_inst_s;

    // Inst is forced once enough data grants have been issued past a waiting inst request.
    assign force_inst_s = LIMIT_EN & (starve_cnt_r >= LIMIT_C) & inst_req;

    // The inst port drives the master fields only while it owns the bus; otherwise the data port does.
    assign sel_inst_s = ~rst & ((state_r == I_ADDR) | (state_r == I_DATA));

    assign mem_wr     = sel_inst_s ? inst_wr    : data_wr;
    assign mem_size   = sel_inst_s ? inst_size  : data_size;
    assign mem_addr   = sel_inst_s ? inst_addr  : data_addr;
    assign mem_wdata  = sel_inst_s ? inst_wdata : data_wdata;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            starve_cnt_r <= CNT_ZERO;
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Grant decision, next-state and handshake routing.
    always_comb begin
        state_s      = state_r;
        starve_cnt_s = starve_cnt_r;
        mem_req      = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (rst) begin
            state_s      = IDLE;
            starve_cnt_s = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (force_inst_s) begin
                        state_s      = I_ADDR;
                        starve_cnt_s = CNT_ZERO;
                    end else if (data_req) begin
                        state_s = D_ADDR;
                        if (!inst_req) begin
                            starve_cnt_s = CNT_ZERO;
                        end else if (starve_cnt_r != CNT_MAX) begin
                            starve_cnt_s = starve_cnt_r + CNT_ONE;
                        end else begin
                            starve_cnt_s = starve_cnt_r;
                        end
                    end else if (inst_req) begin
                        state_s      = I_ADDR;
                        starve_cnt_s = CNT_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end
                I_ADDR: begin
                    mem_req      = inst_req;
                    inst_addr_ok = mem_addr_ok & inst_req;
                    if (!inst_req) begin
                        state_s = IDLE;
                    end else if (mem_addr_ok && mem_data_ok) begin
                        inst_data_ok = 1'b1;
                        state_s      = IDLE;
                    end else if (mem_addr_ok) begin
                        state_s = I_DATA;
                    end else begin
                        state_s = I_ADDR;
                    end
                end
                I_DATA: begin
                    inst_data_ok = mem_data_ok;
                    if (mem_data_ok) begin
                        state_s = IDLE;
                    end else begin
                        state_s = I_DATA;
                    end
                end
                D_ADDR: begin
                    mem_req      = data_req;
                    data_addr_ok = mem_addr_ok & data_req;
                    if (!data_req) begin
                        state_s = IDLE;
                    end else if (mem_addr_ok && mem_data_ok) begin
                        data_data_ok = 1'b1;
                        state_s      = IDLE;
                    end else if (mem_addr_ok) begin
                        state_s = D_DATA;
                    end else begin
                        state_s = D_ADDR;
                    end
                end
                D_DATA: begin
                    data_data_ok = mem_data_ok;
                    if (mem_data_ok) begin
                        state_s = IDLE;
                    end else begin
                        state_s = D_DATA;
                    end
                end
                default: begin
                    state_s      = IDLE;
                    starve_cnt_s = CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter, built with STARVE_LIMIT = 2.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;

    int checks;
    int errors;

    cache_mem_arbiter #(.STARVE_LIMIT(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = 32'h0000_0000; inst_wdata = 32'h0000_0000;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
        data_addr = 32'h0000_0000; data_wdata = 32'h0000_0000;
        mem_rdata = 32'h0000_0000; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

        // Reset: outputs quiet, fields from data port.
        tick(); tick();
        data_addr = 32'hA5A5_0000; inst_addr = 32'h1111_2222;
        settle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'hA5A5_0000);
        tick();
        rst = 1'b0;
        settle();
        chk("rst_state", 32'(dut.state_r), 32'd0);
        chk("rst_cnt", 32'(dut.starve_cnt_r), 32'd0);

        // Single dcache read. t0.
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1004; data_size = 2'd2;
        settle();
        chk("rd_t0_mem_req", 32'(mem_req), 32'd0);
        tick(); settle();   // t1
        chk("rd_t1_mem_req", 32'(mem_req), 32'd1);
        chk("rd_t1_mem_addr", mem_addr, 32'h0000_1004);
        chk("rd_t1_mem_size", 32'(mem_size), 32'd2);
        chk("rd_t1_daddr_ok", 32'(data_addr_ok), 32'd0);
        tick();             // t2
        mem_addr_ok = 1'b1; settle();
        chk("rd_t2_mem_req", 32'(mem_req), 32'd1);
        chk("rd_t2_daddr_ok", 32'(data_addr_ok), 32'd1);
        chk("rd_t2_iaddr_ok", 32'(inst_addr_ok), 32'd0);
        tick();             // t3
        mem_addr_ok = 1'b0; data_req = 1'b0; settle();
        chk("rd_t3_mem_req", 32'(mem_req), 32'd0);
        chk("rd_t3_ddata_ok", 32'(data_data_ok), 32'd0);
        tick();             // t4
        mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; settle();
        chk("rd_t4_ddata_ok", 32'(data_data_ok), 32'd1);
        chk("rd_t4_drdata", data_rdata, 32'hDEAD_BEEF);
        chk("rd_t4_idata_ok", 32'(inst_data_ok), 32'd0);
        tick();             // t5
        mem_data_ok = 1'b0; settle();
        chk("rd_t5_state", 32'(dut.state_r), 32'd0);

        // Simultaneous requests: D first, I after D completes plus one IDLE cycle.
        inst_req = 1'b1; inst_addr = 32'h0000_2000;
        data_req = 1'b1; data_addr = 32'h0000_3000;
        tick();
        mem_addr_ok = 1'b1; settle();
        chk("sim_first_addr", mem_addr, 32'h0000_3000);
        chk("sim_daddr_ok", 32'(data_addr_ok), 32'd1);
        chk("sim_iaddr_ok", 32'(inst_addr_ok), 32'd0);
        tick();
        mem_addr_ok = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1; settle();
        chk("sim_ddata_ok", 32'(data_data_ok), 32'd1);
        tick();
        mem_data_ok = 1'b0; settle();
        chk("sim_bubble_req", 32'(mem_req), 32'd0);
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; settle();
        chk("sim_i_addr", mem_addr, 32'h0000_2000);
        chk("sim_i_req", 32'(mem_req), 32'd1);
        chk("sim_iaddr_ok2", 32'(inst_addr_ok), 32'd1);
        chk("sim_idata_ok", 32'(inst_data_ok), 32'd1);
        chk("sim_daddr_ok2", 32'(data_addr_ok), 32'd0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; inst_req = 1'b0; settle();
        chk("sim_end_state", 32'(dut.state_r), 32'd0);

        // Starvation with limit 2: grant order D, D, I, D (same-cycle finish each).
        inst_req = 1'b1; inst_addr = 32'h0000_7000;
        data_req = 1'b1; data_addr = 32'h0000_8000;
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; settle();
        chk("stv_g1_addr", mem_addr, 32'h0000_8000);
        chk("stv_g1_daddr_ok", 32'(data_addr_ok), 32'd1);
        chk("stv_g1_ddata_ok", 32'(data_data_ok), 32'd1);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; settle();
        chk("stv_g1_no_ddata", 32'(dut.state_r), 32'd0);
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; settle();
        chk("stv_g2_addr", mem_addr, 32'h0000_8000);
        chk("stv_g2_cnt", 32'(dut.starve_cnt_r), 32'd2);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; settle();
        chk("stv_g3_addr", mem_addr, 32'h0000_7000);
        chk("stv_g3_iaddr_ok", 32'(inst_addr_ok), 32'd1);
        chk("stv_g3_daddr_ok", 32'(data_addr_ok), 32'd0);
        chk("stv_g3_cnt", 32'(dut.starve_cnt_r), 32'd0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; settle();
        chk("stv_g4_addr", mem_addr, 32'h0000_8000);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        tick();

        // Dirty writeback then refill.
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0040_0010; data_wdata = 32'h1234_5678;
        tick();
        mem_addr_ok = 1'b1; settle();
        chk("wb_mem_wr", 32'(mem_wr), 32'd1);
        chk("wb_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("wb_mem_addr", mem_addr, 32'h0040_0010);
        tick();
        mem_addr_ok = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1; settle();
        chk("wb_state_data", 32'(dut.state_r), 32'd4);
        chk("wb_ddata_ok", 32'(data_data_ok), 32'd1);
        tick();
        mem_data_ok = 1'b0; data_req = 1'b1; data_wr = 1'b0;
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; settle();
        chk("rf_mem_req", 32'(mem_req), 32'd1);
        chk("rf_mem_wr", 32'(mem_wr), 32'd0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; data_req = 1'b0;
        tick();

        // Request dropped before accept returns to IDLE without issuing.
        data_req = 1'b1;
        tick();
        data_req = 1'b0; settle();
        chk("drop_mem_req", 32'(mem_req), 32'd0);
        tick(); settle();
        chk("drop_state", 32'(dut.state_r), 32'd0);

        // Reset during I_DATA, stale data_ok after release is dropped.
        inst_req = 1'b1; inst_addr = 32'h0000_5000;
        tick();
        mem_addr_ok = 1'b1; settle();
        chk("rm_iaddr_ok", 32'(inst_addr_ok), 32'd1);
        chk("rm_i_addr", mem_addr, 32'h0000_5000);
        tick();
        mem_addr_ok = 1'b0; inst_req = 1'b0; settle();
        chk("rm_state_idata", 32'(dut.state_r), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0; settle();
        chk("rm_state_idle", 32'(dut.state_r), 32'd0);
        tick();
        mem_data_ok = 1'b1; settle();
        chk("rm_idata_ok", 32'(inst_data_ok), 32'd0);
        chk("rm_ddata_ok", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 1'b0; settle();
        chk("rm_state_final", 32'(dut.state_r), 32'd0);
        chk("rm_cnt", 32'(dut.starve_cnt_r), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
